// File: rtl/phy_pkg.sv
// phy_pkg: shared AXI-Stream widths, arbiter state encoding and a clog2 helper
package phy_pkg;
  localparam int DATA_W = 32;
  localparam int KEEP_W = 4;
  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} arb_state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/phy_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector; first request found upward from last+1, wrapping
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         any,
  output logic [W-1:0] idx
);
  assign any = |req;
  always_comb begin
    int k;
    k = 0;
    idx = '0;
    // scan from farthest to nearest so the nearest requester wins
    for (int i = N; i >= 1; i--) begin
      k = (int'(last) + i) % N;
      if (req[k]) idx = W'(k);
    end
  end
endmodule

// File: rtl/phy_tx_arbiter.sv
// phy_tx_arbiter: packet-granular round-robin arbiter sharing one PHY TX AXI-Stream port
module phy_tx_arbiter
  import phy_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CH_W        = 2,
  parameter int STALL_LIMIT = 1024
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_CH-1:0]        i_axi_s_valid,
  input  logic [NUM_CH*DATA_W-1:0] i_axi_s_data,
  input  logic [NUM_CH*KEEP_W-1:0] i_axi_s_keep,
  input  logic [NUM_CH-1:0]        i_axi_s_last,
  output logic [NUM_CH-1:0]        o_axi_s_ready,
  output logic                     o_axi_m_valid,
  output logic [DATA_W-1:0]        o_axi_m_data,
  output logic [KEEP_W-1:0]        o_axi_m_keep,
  output logic                     o_axi_m_last,
  input  logic                     i_axi_m_ready,
  output logic [CH_W-1:0]          o_grant_id,
  output logic                     o_busy,
  output logic                     o_stall
);
  localparam int CNT_W = clog2(STALL_LIMIT + 1);
  arb_state_t state, state_nx;
  logic [CH_W-1:0] grant, last_grant, pick;
  logic [CNT_W-1:0] cnt;
  logic any, xfer, valid_g, hs;
  rr_pick #(.N(NUM_CH), .W(CH_W)) u_pick (
    .req (i_axi_s_valid),
    .last(last_grant),
    .any (any),
    .idx (pick)
  );
  assign xfer    = state == XFER;
  assign valid_g = i_axi_s_valid[grant];
  assign hs      = xfer & valid_g & i_axi_m_ready;
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= CH_W'(NUM_CH - 1);
      cnt        <= '0;
    end else begin
      state <= state_nx;
      if (!xfer && any) grant <= pick;
      if (hs && i_axi_s_last[grant]) last_grant <= grant;
      cnt <= (!xfer || hs) ? '0 : (!valid_g && cnt != CNT_W'(STALL_LIMIT)) ? cnt + 1'b1 : cnt;
    end
  always_comb
    state_nx = xfer ? ((hs && i_axi_s_last[grant]) ? IDLE : XFER) : (any ? XFER : IDLE);
  always_comb begin
    o_busy        = xfer;
    o_axi_m_valid = xfer & valid_g;
    o_axi_m_data  = o_axi_m_valid ? i_axi_s_data[int'(grant)*DATA_W +: DATA_W] : '0;
    o_axi_m_keep  = o_axi_m_valid ? i_axi_s_keep[int'(grant)*KEEP_W +: KEEP_W] : '0;
    o_axi_m_last  = o_axi_m_valid & i_axi_s_last[grant];
    o_axi_s_ready = xfer ? NUM_CH'(i_axi_m_ready) << grant : '0;
    o_grant_id    = xfer ? grant : '0;
    o_stall       = xfer & ~valid_g & (cnt == CNT_W'(STALL_LIMIT - 1));
  end
endmodule

// File: tb/tb_phy_tx_arbiter.sv
// tb_phy_tx_arbiter: scoreboard bench for the round-robin PHY TX arbiter
module tb_phy_tx_arbiter;
  localparam int N = 4;
  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    int          ch;
  } beat_t;
  logic clk = 0;
  logic rst = 1;
  logic [N-1:0] valid, last, s_ready;
  logic [N*32-1:0] data;
  logic [N*4-1:0] keep;
  logic m_valid, m_last, m_ready, busy, stall;
  logic [31:0] m_data;
  logic [3:0] m_keep;
  logic [1:0] grant_id;
  int checks = 0, errors = 0, hs_total = 0, gap = -1;
  bit gap_chk = 0;
  beat_t exp_q[$];
  beat_t src_q[N][$];
  logic [N-1:0] hs_ch = '0;
  logic prev_v = 0, prev_r = 0, prev_l = 0;
  logic [31:0] prev_d = '0;
  logic [3:0] prev_k = '0;

  phy_tx_arbiter #(.NUM_CH(N), .CH_W(2), .STALL_LIMIT(8)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_axi_s_valid(valid),
    .i_axi_s_data (data),
    .i_axi_s_keep (keep),
    .i_axi_s_last (last),
    .o_axi_s_ready(s_ready),
    .o_axi_m_valid(m_valid),
    .o_axi_m_data (m_data),
    .o_axi_m_keep (m_keep),
    .o_axi_m_last (m_last),
    .i_axi_m_ready(m_ready),
    .o_grant_id   (grant_id),
    .o_busy       (busy),
    .o_stall      (stall)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic int pending();
    int s;
    s = 0;
    for (int c = 0; c < N; c++) s += src_q[c].size();
    return s;
  endfunction

  task automatic add_beat(input int ch, input logic [31:0] d, input logic [3:0] k, input logic l,
                          input bit to_src, input bit to_exp);
    beat_t b;
    b.d = d;
    b.k = k;
    b.l = l;
    b.ch = ch;
    if (to_src) src_q[ch].push_back(b);
    if (to_exp) exp_q.push_back(b);
  endtask

  task automatic send_pkt(input int ch, input int n, input logic [31:0] base, input logic [3:0] k);
    for (int i = 0; i < n; i++) add_beat(ch, base + 32'(i), k, i == n - 1, 1, 1);
  endtask

  task automatic flush();
    exp_q.delete();
    for (int c = 0; c < N; c++) src_q[c].delete();
  endtask

  task automatic zero_chk(input string p);
    chk({p, "_s_ready"}, 32'(s_ready), 0);
    chk({p, "_m_valid"}, 32'(m_valid), 0);
    chk({p, "_m_data"}, m_data, 0);
    chk({p, "_m_keep"}, 32'(m_keep), 0);
    chk({p, "_m_last"}, 32'(m_last), 0);
    chk({p, "_grant"}, 32'(grant_id), 0);
    chk({p, "_busy"}, 32'(busy), 0);
    chk({p, "_stall"}, 32'(stall), 0);
  endtask

  task automatic do_reset(input string p);
    rst = 0;
    #1;
    zero_chk(p);
    flush();
    repeat (3) tick();
    rst = 1;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || pending() > 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    chk("drain", 32'(exp_q.size()), 0);
  endtask

  task automatic wait_hs(input int budget);
    int h0, n;
    h0 = hs_total;
    n = 0;
    while (hs_total == h0 && n < budget) begin
      tick();
      n++;
    end
    chk("hs_seen", 32'(hs_total), 32'(h0 + 1));
  endtask

  // sources advance right after the edge on which their beat was accepted
  task automatic driver();
    forever begin
      @(posedge clk);
      #1;
      for (int c = 0; c < N; c++) begin
        if (hs_ch[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
        valid[c] = src_q[c].size() > 0;
        if (valid[c]) begin
          data[32*c +: 32] = src_q[c][0].d;
          keep[4*c +: 4]   = src_q[c][0].k;
          last[c]          = src_q[c][0].l;
        end else begin
          data[32*c +: 32] = '0;
          keep[4*c +: 4]   = '0;
          last[c]          = 1'b0;
        end
      end
    end
  endtask

  task automatic monitor();
    beat_t e;
    forever begin
      @(negedge clk);
      hs_ch = valid & s_ready;
      if (!rst) begin
        prev_v = 0;
        gap = -1;
      end else begin
        if (m_valid && prev_v && !prev_r) begin
          chk("hold_data", m_data, prev_d);
          chk("hold_keep", 32'(m_keep), 32'(prev_k));
          chk("hold_last", 32'(m_last), 32'(prev_l));
        end
        if (m_valid && gap >= 0) begin
          if (gap_chk) chk("bubble", 32'(gap), 1);
          else chk("bubble_nonzero", 32'(gap > 0), 1);
          gap = -1;
        end else if (!m_valid && gap >= 0) gap++;
        if (m_valid && m_ready) begin
          hs_total++;
          chk("exp_avail", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("beat_data", m_data, e.d);
            chk("beat_keep", 32'(m_keep), 32'(e.k));
            chk("beat_last", 32'(m_last), 32'(e.l));
            chk("beat_grant", 32'(grant_id), 32'(e.ch));
          end
          if (m_last) gap = 0;
        end
        prev_v = m_valid;
        prev_r = m_ready;
        prev_d = m_data;
        prev_k = m_keep;
        prev_l = m_last;
      end
    end
  endtask

  initial begin
    int h0;
    logic [6:0] pat;
    valid = '0;
    data = '0;
    keep = '0;
    last = '0;
    m_ready = 1;
    fork
      monitor();
      driver();
    join_none
    #2;
    do_reset("rst");
    // single 3-beat packet from ch2, one-cycle arbitration bubble
    send_pkt(2, 3, 32'hA0, 4'hF);
    tick();
    chk("t1_busy_bubble", 32'(busy), 0);
    chk("t1_valid_bubble", 32'(m_valid), 0);
    tick();
    chk("t1_busy", 32'(busy), 1);
    chk("t1_grant", 32'(grant_id), 2);
    wait_done(50);
    chk("t1_idle", 32'(busy), 0);
    // all channels continuously requesting: order 0,1,2,3,0 with one bubble each
    do_reset("rst2");
    gap_chk = 1;
    for (int c = 0; c < N; c++) send_pkt(c, 2, 32'h100 + 32'(c) * 16, 4'hF);
    send_pkt(0, 2, 32'h140, 4'hF);
    wait_done(100);
    gap_chk = 0;
    // backpressure on a ch1 packet
    pat = 7'b1011001;
    send_pkt(1, 3, 32'hB0, 4'h7);
    tick();
    h0 = hs_total;
    for (int i = 0; i < 7; i++) begin
      m_ready = pat[i];
      #1;
      if (i > 0) chk("bp_sready", 32'(s_ready[1]), 32'(m_ready));
      tick();
    end
    m_ready = 1;
    chk("bp_hs_count", 32'(hs_total - h0), 3);
    chk("bp_idle", 32'(busy), 0);
    // stall: ch0 goes quiet mid-packet while ch3 waits
    add_beat(0, 32'hC0, 4'hF, 0, 1, 1);
    wait_hs(30);
    add_beat(3, 32'hC3, 4'hF, 1, 1, 0);
    for (int i = 1; i <= 12; i++) begin
      chk("stall_pulse", 32'(stall), 32'(i == 8));
      chk("stall_grant", 32'(grant_id), 0);
      tick();
    end
    add_beat(0, 32'hC1, 4'hF, 1, 1, 1);
    add_beat(3, 32'hC3, 4'hF, 1, 0, 1);
    wait_done(50);
    // single-beat packets with last_grant=1: ch3 before ch1
    send_pkt(1, 1, 32'hD0, 4'h1);
    wait_done(30);
    send_pkt(3, 1, 32'hD3, 4'h1);
    send_pkt(1, 1, 32'hD1, 4'h1);
    wait_done(30);
    // reset during beat 2 of a ch2 packet
    send_pkt(2, 4, 32'hE0, 4'hF);
    wait_hs(30);
    chk("mid_valid", 32'(m_valid), 1);
    chk("mid_data", m_data, 32'hE1);
    rst = 0;
    #1;
    zero_chk("mid");
    flush();
    send_pkt(1, 2, 32'hF0, 4'hF);
    send_pkt(2, 2, 32'hF8, 4'hF);
    tick();
    tick();
    rst = 1;
    wait_done(50);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
